// File: rtl/lsu_pkg.sv
// Shared types for the DMEM load/store unit: access sizes, FSM state codes and lane masks.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } lsu_size_e;

   // State codes kept as plain constants so older tooling can match on raw values.
   typedef logic [2:0] lsu_state_e;
   localparam lsu_state_e ST_IDLE   = 3'd0;
   localparam lsu_state_e ST_LOAD   = 3'd1;
   localparam lsu_state_e ST_RMW_RD = 3'd2;
   localparam lsu_state_e ST_WRITE  = 3'd3;
   localparam lsu_state_e ST_RESP   = 3'd4;

   function automatic logic [3:0] lane_mask(input lsu_size_e size, input logic [1:0] lane);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << lane;
         SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, merges sub-word store data into an old word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_size_e   size,
   input  logic        is_unsigned,
   input  logic [1:0]  lane,
   input  logic [31:0] ld_word,
   input  logic [31:0] st_data,
   output logic [31:0] ld_ext,
   output logic [31:0] st_word
);

   logic [31:0] shifted;
   logic [31:0] replicated;
   logic [3:0]  mask;

   assign shifted = ld_word >> {lane, 3'b000};
   assign mask    = lane_mask(size, lane);

   always_comb begin
      ld_ext = ld_word;
      case (size)
         SZ_BYTE: ld_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         SZ_HALF: ld_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: ld_ext = ld_word;
      endcase
   end

   // Replicating the right-aligned data puts a copy in every lane, so the mask alone selects it.
   always_comb begin
      replicated = st_data;
      case (size)
         SZ_BYTE: replicated = {4{st_data[7:0]}};
         SZ_HALF: replicated = {2{st_data[15:0]}};
         default: replicated = st_data;
      endcase
   end

   always_comb begin
      st_word = ld_word;
      for (int k = 0; k < 4; k++) begin
         st_word[8*k +: 8] = mask[k] ? replicated[8*k +: 8] : ld_word[8*k +: 8];
      end
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-organised DMEM; sub-word stores use read-modify-write.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int          N         = 32,
   parameter int          ADDR_W    = 11,
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [31:0]       req_addr_i,
   input  logic [N-1:0]      req_wdata_i,
   output logic              resp_valid_o,
   output logic              resp_err_o,
   output logic [N-1:0]      resp_rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [N-1:0]      mem_st_data_o,
   output logic              mem_st_en_o,
   input  logic [N-1:0]      mem_ld_data_i
);

   lsu_state_e  state;
   lsu_size_e   size_in;
   lsu_size_e   size_q;
   logic        uns_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] offset;
   logic        out_of_window;
   logic        misaligned;
   logic        req_err;
   logic [31:0] ld_ext;
   logic [31:0] st_word;

   assign size_in       = lsu_size_e'(req_size_i);
   assign offset        = req_addr_i - BASE_ADDR;
   // Addresses below the base wrap to huge offsets and are caught by the same window test.
   assign out_of_window = |offset[31:ADDR_W+2];
   assign misaligned    = ((size_in == SZ_HALF) && offset[0]) ||
                          ((size_in == SZ_WORD) && (offset[1:0] != 2'b00));
   assign req_err       = out_of_window || misaligned || (size_in == SZ_RSVD);
   assign req_ready_o   = (state == ST_IDLE);

   lsu_lane_align u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .lane        (lane_q),
      .ld_word     (mem_ld_data_i),
      .st_data     (wdata_q),
      .ld_ext      (ld_ext),
      .st_word     (st_word)
   );

   // DMEM gates its register clocks with st_en, so every DMEM-facing output comes straight from a flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= ST_IDLE;
         size_q        <= SZ_BYTE;
         uns_q         <= 1'b0;
         lane_q        <= 2'b00;
         wdata_q       <= '0;
         resp_valid_o  <= 1'b0;
         resp_err_o    <= 1'b0;
         resp_rdata_o  <= '0;
         mem_addr_o    <= '0;
         mem_st_data_o <= '0;
         mem_st_en_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  size_q  <= size_in;
                  uns_q   <= req_unsigned_i;
                  lane_q  <= offset[1:0];
                  wdata_q <= req_wdata_i;
                  if (req_err) begin
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                     state        <= ST_RESP;
                  end else begin
                     mem_addr_o <= offset[ADDR_W+1:2];
                     if (!req_we_i) begin
                        state <= ST_LOAD;
                     end else if (size_in == SZ_WORD) begin
                        mem_st_data_o <= req_wdata_i;
                        mem_st_en_o   <= 1'b1;
                        state         <= ST_WRITE;
                     end else begin
                        state <= ST_RMW_RD;
                     end
                  end
               end
            end
            ST_LOAD: begin
               resp_rdata_o <= ld_ext;
               resp_valid_o <= 1'b1;
               resp_err_o   <= 1'b0;
               state        <= ST_RESP;
            end
            ST_RMW_RD: begin
               mem_st_data_o <= st_word;
               mem_st_en_o   <= 1'b1;
               state         <= ST_WRITE;
            end
            ST_WRITE: begin
               mem_st_en_o  <= 1'b0;
               resp_valid_o <= 1'b1;
               resp_err_o   <= 1'b0;
               resp_rdata_o <= '0;
               state        <= ST_RESP;
            end
            ST_RESP: begin
               resp_valid_o <= 1'b0;
               resp_err_o   <= 1'b0;
               state        <= ST_IDLE;
            end
            default: begin
               resp_valid_o <= 1'b0;
               resp_err_o   <= 1'b0;
               mem_st_en_o  <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
